// File: rtl/game_seq_pkg.sv
// Shared types and constants for the game sequencer: FSM state encoding,
// speed-level limits, game-reset length and the level-to-period mapping.
package game_seq_pkg;

    typedef enum logic [2:0] {
        S_GRST  = 3'd0,
        S_WAIT  = 3'd1,
        S_RUN   = 3'd2,
        S_BUSY  = 3'd3,
        S_PAUSE = 3'd4,
        S_FAIL  = 3'd5,
        S_WIN   = 3'd6
    } game_state_t;

    localparam logic [2:0] LEVEL_MIN   = 3'd0;
    localparam logic [2:0] LEVEL_MAX   = 3'd7;
    localparam logic [2:0] LEVEL_RST   = 3'd3;
    localparam int         GRST_CYCLES = 2;
    localparam int         PERIOD_W    = 5;

    // Frames between game steps: 16 at level 0 down to 2 at level 7.
    function automatic logic [PERIOD_W-1:0] level_period(input logic [2:0] level);
        return PERIOD_W'(16) - {1'b0, level, 1'b0};
    endfunction

endpackage

// File: rtl/game_seq_frame_divider.sv
// Counts vsync pulses while enabled and flags the vsync that completes a period.
// The period is captured on the first vsync of each period, so level changes apply from the next one.
module frame_divider
    import game_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                vsync,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                due
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        per_d = per_q;
        due   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && vsync) begin
            if (cnt_q == '0) begin
                per_d = period;
            end
            if (cnt_q != '0 && cnt_q == per_q - 1'b1) begin
                due   = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            per_q <= PERIOD_W'(16);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/game_seq.sv
// Game sequencer: reset/wait/run/busy/pause/fail/win FSM that paces snake steps
// from vsync, tracks score and speed level, and drives the game-wide reset.
module game_seq
    import game_seq_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vsync,
    input  logic       i_pause,
    input  logic       i_restart,
    input  logic       i_start,
    input  logic       i_apple_ready,
    input  logic       i_tick_done,
    input  logic       i_snake_failure,
    input  logic       i_snake_success,
    input  logic       i_eat,
    input  logic       i_speed_up,
    input  logic       i_speed_down,
    output logic       o_tick,
    output logic       o_game_rst,
    output logic [2:0] o_state,
    output logic       o_failure,
    output logic       o_success,
    output logic       o_paused,
    output logic [7:0] o_score,
    output logic [2:0] o_level
);

    localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

    game_state_t       state_q, state_d;
    logic [1:0]        grst_cnt_q, grst_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;
    logic              game_rst_q, game_rst_d;
    logic              failure_q, failure_d;
    logic              success_q, success_d;
    logic              paused_q, paused_d;
    logic [7:0]        score_q, score_d;
    logic [2:0]        level_q, level_d;
    logic              due;

    frame_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .vsync  (i_vsync),
        .enable (state_q == S_RUN),
        .clear  (state_q == S_GRST),
        .period (level_period(level_q)),
        .due    (due)
    );

    always_comb begin
        state_d    = state_q;
        grst_cnt_d = grst_cnt_q;
        busy_cnt_d = '0;
        pend_d     = 1'b0;
        tick_d     = 1'b0;
        if (i_restart) begin
            state_d    = S_GRST;
            grst_cnt_d = '0;
        end else begin
            case (state_q)
                S_GRST: begin
                    if (grst_cnt_q == 2'(GRST_CYCLES - 1)) state_d = S_WAIT;
                    else grst_cnt_d = grst_cnt_q + 1'b1;
                end
                S_WAIT: if (i_start && i_apple_ready) state_d = S_RUN;
                S_RUN: begin
                    if (i_snake_failure)           state_d = S_FAIL;
                    else if (i_snake_success)      state_d = S_WIN;
                    else if (due && i_apple_ready) begin
                        state_d = S_BUSY;
                        tick_d  = 1'b1;
                        pend_d  = i_pause;
                    end else if (i_pause)          state_d = S_PAUSE;
                end
                S_BUSY: begin
                    // A pause request seen while busy is held until the step completes.
                    if (i_snake_failure)      state_d = S_FAIL;
                    else if (i_snake_success) state_d = S_WIN;
                    else if (i_tick_done || busy_cnt_q == BUSY_W'(BUSY_TIMEOUT - 1))
                        state_d = (pend_q || i_pause) ? S_PAUSE : S_RUN;
                    else begin
                        busy_cnt_d = busy_cnt_q + 1'b1;
                        pend_d     = pend_q || i_pause;
                    end
                end
                S_PAUSE: if (!i_pause) state_d = S_RUN;
                default: ;
            endcase
        end

        game_rst_d = (state_d == S_GRST);
        failure_d  = (state_d == S_FAIL);
        success_d  = (state_d == S_WIN);
        paused_d   = (state_d == S_PAUSE);

        score_d = score_q;
        if (state_q == S_GRST)               score_d = '0;
        else if (i_eat && score_q != 8'hFF)  score_d = score_q + 1'b1;

        level_d = level_q;
        if (i_speed_up && !i_speed_down && level_q != LEVEL_MAX)      level_d = level_q + 1'b1;
        else if (i_speed_down && !i_speed_up && level_q != LEVEL_MIN) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_GRST;
            grst_cnt_q <= '0;
            busy_cnt_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            game_rst_q <= 1'b1;
            failure_q  <= 1'b0;
            success_q  <= 1'b0;
            paused_q   <= 1'b0;
            score_q    <= '0;
            level_q    <= LEVEL_RST;
        end else begin
            state_q    <= state_d;
            grst_cnt_q <= grst_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            game_rst_q <= game_rst_d;
            failure_q  <= failure_d;
            success_q  <= success_d;
            paused_q   <= paused_d;
            score_q    <= score_d;
            level_q    <= level_d;
        end
    end

    assign o_tick     = tick_q;
    assign o_game_rst = game_rst_q;
    assign o_state    = state_q;
    assign o_failure  = failure_q;
    assign o_success  = success_q;
    assign o_paused   = paused_q;
    assign o_score    = score_q;
    assign o_level    = level_q;

endmodule

// File: tb/tb_game_seq.sv
// Self-checking bench for game_seq: directed vector table, corner-case sequences
// and a randomized run, all compared against a rule-level reference model.
`timescale 1ns/1ps
module tb_game_seq;
    import game_seq_pkg::*;

    localparam int BUSY_TIMEOUT = 1023;

    typedef logic [11:0] stim_t;
    localparam stim_t I_RST   = 12'h800, I_RESTART = 12'h400, I_START = 12'h200, I_APPLE = 12'h100;
    localparam stim_t I_VSYNC = 12'h080, I_PAUSE   = 12'h040, I_TDONE = 12'h020, I_SFAIL = 12'h010;
    localparam stim_t I_SWIN  = 12'h008, I_EAT     = 12'h004, I_UP    = 12'h002, I_DOWN  = 12'h001;
    localparam stim_t ON      = I_START | I_APPLE;

    typedef struct {
        stim_t       s;
        game_state_t st;
        logic        tick;
        logic        grst;
        logic [7:0]  score;
        logic [2:0]  level;
    } vec_t;

    logic clk = 1'b0;
    logic rst, i_vsync, i_pause, i_restart, i_start, i_apple_ready, i_tick_done;
    logic i_snake_failure, i_snake_success, i_eat, i_speed_up, i_speed_down;
    logic o_tick, o_game_rst, o_failure, o_success, o_paused;
    logic [2:0] o_state, o_level;
    logic [7:0] o_score;

    always #5 clk = ~clk;

    game_seq #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_pause(i_pause), .i_restart(i_restart),
        .i_start(i_start), .i_apple_ready(i_apple_ready), .i_tick_done(i_tick_done),
        .i_snake_failure(i_snake_failure), .i_snake_success(i_snake_success), .i_eat(i_eat),
        .i_speed_up(i_speed_up), .i_speed_down(i_speed_down), .o_tick(o_tick),
        .o_game_rst(o_game_rst), .o_state(o_state), .o_failure(o_failure),
        .o_success(o_success), .o_paused(o_paused), .o_score(o_score), .o_level(o_level)
    );

    int n_checks = 0, n_fails = 0, cyc = 0, tick_seen = 0, grst_seen = 0;

    // Reference model: plain counters of frames seen, cycles left and points.
    game_state_t m_state;
    int m_grst_left, m_frames, m_per, m_busy_left, m_score, m_level;
    bit m_pend, m_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input stim_t s);
        game_state_t nxt;
        bit due;
        if ((s & I_RST) != 0) begin
            m_state = S_GRST; m_grst_left = GRST_CYCLES; m_frames = 0; m_score = 0;
            m_level = 3; m_tick = 0; m_pend = 0;
            return;
        end
        due = 0;
        nxt = m_state;
        m_tick = 0;
        if (m_state == S_GRST) m_frames = 0;
        else if (m_state == S_RUN && (s & I_VSYNC) != 0) begin
            if (m_frames == 0) m_per = 16 - 2 * m_level;
            m_frames++;
            if (m_frames == m_per) begin due = 1; m_frames = 0; end
        end
        if (m_state == S_GRST) m_score = 0;
        else if ((s & I_EAT) != 0 && m_score < 255) m_score++;
        if ((s & I_UP) != 0 && (s & I_DOWN) == 0 && m_level < 7) m_level++;
        else if ((s & I_DOWN) != 0 && (s & I_UP) == 0 && m_level > 0) m_level--;
        if ((s & I_RESTART) != 0) begin
            nxt = S_GRST; m_grst_left = GRST_CYCLES; m_pend = 0;
        end else begin
            case (m_state)
                S_GRST: begin m_grst_left--; if (m_grst_left == 0) nxt = S_WAIT; end
                S_WAIT: if ((s & ON) == ON) nxt = S_RUN;
                S_RUN: begin
                    if ((s & I_SFAIL) != 0) nxt = S_FAIL;
                    else if ((s & I_SWIN) != 0) nxt = S_WIN;
                    else if (due && (s & I_APPLE) != 0) begin
                        nxt = S_BUSY; m_tick = 1; m_busy_left = BUSY_TIMEOUT;
                        m_pend = (s & I_PAUSE) != 0;
                    end else if ((s & I_PAUSE) != 0) nxt = S_PAUSE;
                end
                S_BUSY: begin
                    if ((s & I_SFAIL) != 0) nxt = S_FAIL;
                    else if ((s & I_SWIN) != 0) nxt = S_WIN;
                    else begin
                        if ((s & I_PAUSE) != 0) m_pend = 1;
                        m_busy_left--;
                        if ((s & I_TDONE) != 0 || m_busy_left == 0) begin
                            nxt = m_pend ? S_PAUSE : S_RUN;
                            m_pend = 0;
                        end
                    end
                end
                S_PAUSE: if ((s & I_PAUSE) == 0) nxt = S_RUN;
                default: ;
            endcase
        end
        m_state = nxt;
    endtask

    task automatic step(input stim_t s);
        rst = s[11]; i_restart = s[10]; i_start = s[9]; i_apple_ready = s[8];
        i_vsync = s[7]; i_pause = s[6]; i_tick_done = s[5]; i_snake_failure = s[4];
        i_snake_success = s[3]; i_eat = s[2]; i_speed_up = s[1]; i_speed_down = s[0];
        @(posedge clk);
        model_step(s);
        #1;
        cyc++;
        if (o_tick) tick_seen++;
        if (o_game_rst) grst_seen++;
        check("model state", 32'(o_state), 32'(m_state));
        check("model tick", 32'(o_tick), 32'(m_tick));
        check("model game_rst", 32'(o_game_rst), 32'(m_state == S_GRST));
        check("model failure", 32'(o_failure), 32'(m_state == S_FAIL));
        check("model success", 32'(o_success), 32'(m_state == S_WIN));
        check("model paused", 32'(o_paused), 32'(m_state == S_PAUSE));
        check("model score", 32'(o_score), 32'(m_score));
        check("model level", 32'(o_level), 32'(m_level));
    endtask

    function automatic vec_t mk(input stim_t s, input game_state_t st, input logic tick,
                                input logic grst, input logic [7:0] score, input logic [2:0] level);
        vec_t v;
        v.s = s; v.st = st; v.tick = tick; v.grst = grst; v.score = score; v.level = level;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   n;
        vecs.push_back(mk(I_RST,            S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk('0,               S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk('0,               S_WAIT, 0, 0, 0, 3));
        vecs.push_back(mk(I_EAT,            S_WAIT, 0, 0, 1, 3));
        vecs.push_back(mk(I_UP,             S_WAIT, 0, 0, 1, 4));
        vecs.push_back(mk(I_UP | I_DOWN,    S_WAIT, 0, 0, 1, 4));
        vecs.push_back(mk(I_DOWN,           S_WAIT, 0, 0, 1, 3));
        vecs.push_back(mk(I_START,          S_WAIT, 0, 0, 1, 3));
        vecs.push_back(mk(ON,               S_RUN,  0, 0, 1, 3));
        vecs.push_back(mk(ON | I_SFAIL | I_SWIN, S_FAIL, 0, 0, 1, 3));
        vecs.push_back(mk(I_EAT,            S_FAIL, 0, 0, 2, 3));
        vecs.push_back(mk(I_RESTART,        S_GRST, 0, 1, 2, 3));
        vecs.push_back(mk('0,               S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk('0,               S_WAIT, 0, 0, 0, 3));
        vecs.push_back(mk(ON | I_SWIN,      S_RUN,  0, 0, 0, 3));
        vecs.push_back(mk(I_SWIN,           S_WIN,  0, 0, 0, 3));
        vecs.push_back(mk(I_RESTART,        S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk(I_RESTART,        S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk('0,               S_GRST, 0, 1, 0, 3));
        vecs.push_back(mk('0,               S_WAIT, 0, 0, 0, 3));
        foreach (vecs[i]) begin
            step(vecs[i].s);
            check($sformatf("vec%0d state", i), 32'(o_state), 32'(vecs[i].st));
            check($sformatf("vec%0d tick", i), 32'(o_tick), 32'(vecs[i].tick));
            check($sformatf("vec%0d game_rst", i), 32'(o_game_rst), 32'(vecs[i].grst));
            check($sformatf("vec%0d score", i), 32'(o_score), 32'(vecs[i].score));
            check($sformatf("vec%0d level", i), 32'(o_level), 32'(vecs[i].level));
        end

        // One tick after ten frames at level 3, then back to RUN on tick_done.
        step(I_RST); step('0); step('0); step(ON);
        check("run entry", 32'(o_state), 32'(S_RUN));
        tick_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            step(ON | I_VSYNC);
            if (i < 10) begin step(ON); step(ON); end
        end
        check("p10 tick", 32'(o_tick), 1);
        check("p10 busy", 32'(o_state), 32'(S_BUSY));
        step(ON | I_TDONE);
        check("p10 tick count", 32'(tick_seen), 1);
        check("tick_done to run", 32'(o_state), 32'(S_RUN));

        // Apple not ready at period end: tick dropped, next one ten frames later.
        tick_seen = 0;
        for (int i = 1; i <= 9; i++) begin step(ON | I_VSYNC); step(ON); end
        step(I_START | I_VSYNC);
        check("dropped tick", 32'(o_tick), 0);
        check("dropped state", 32'(o_state), 32'(S_RUN));
        for (int i = 1; i <= 10; i++) begin
            step(ON | I_VSYNC);
            if (i == 10) check("tick after drop", 32'(o_tick), 1);
            step(ON);
        end
        check("drop tick count", 32'(tick_seen), 1);
        step(ON | I_TDONE);

        // Pause requested while busy takes effect only after tick_done.
        for (int i = 1; i <= 10; i++) begin step(ON | I_VSYNC); if (i < 10) step(ON); end
        check("pause busy entry", 32'(o_state), 32'(S_BUSY));
        step(ON | I_PAUSE); step(ON | I_PAUSE); step(ON | I_PAUSE);
        check("pause deferred", 32'(o_state), 32'(S_BUSY));
        step(ON | I_PAUSE | I_TDONE);
        check("pause entered", 32'(o_state), 32'(S_PAUSE));
        tick_seen = 0;
        for (int i = 0; i < 30; i++) begin step(ON | I_PAUSE | I_VSYNC); step(ON | I_PAUSE); end
        check("pause no tick", 32'(tick_seen), 0);
        check("pause flag", 32'(o_paused), 1);
        step(ON);
        check("pause release", 32'(o_state), 32'(S_RUN));

        // Failure and success together: failure wins; restart pulse gives two reset cycles.
        step(ON | I_SFAIL | I_SWIN);
        check("both fail state", 32'(o_state), 32'(S_FAIL));
        check("both o_failure", 32'(o_failure), 1);
        check("both o_success", 32'(o_success), 0);
        grst_seen = 0;
        step(I_RESTART);
        for (int i = 0; i < 4; i++) step('0);
        check("restart game_rst cycles", 32'(grst_seen), 2);
        check("restart to wait", 32'(o_state), 32'(S_WAIT));

        // Score and level saturation; level survives restart.
        for (int i = 0; i < 300; i++) step(I_EAT);
        check("score saturate", 32'(o_score), 255);
        for (int i = 0; i < 9; i++) step(I_UP);
        check("level saturate", 32'(o_level), 7);
        step(ON);
        step(ON | I_VSYNC);
        check("p2 first vsync", 32'(o_tick), 0);
        step(ON | I_VSYNC);
        check("p2 tick", 32'(o_tick), 1);
        step(ON | I_TDONE);
        step(I_RESTART); step('0); step('0);
        check("restart score", 32'(o_score), 0);
        check("restart level", 32'(o_level), 7);

        // Busy timeout without tick_done.
        step(ON); step(ON | I_VSYNC); step(ON | I_VSYNC);
        check("timeout busy entry", 32'(o_state), 32'(S_BUSY));
        n = 0;
        while (o_state == S_BUSY && n < 2000) begin step(ON); n++; end
        check("busy timeout cycles", 32'(n), BUSY_TIMEOUT);
        check("timeout to run", 32'(o_state), 32'(S_RUN));

        // Reset mid-BUSY and mid-PAUSE drops pending work.
        step(ON | I_VSYNC); step(ON | I_VSYNC | I_PAUSE);
        check("rst busy entry", 32'(o_state), 32'(S_BUSY));
        tick_seen = 0;
        step(I_RST);
        check("rst busy state", 32'(o_state), 32'(S_GRST));
        check("rst busy level", 32'(o_level), 3);
        step('0); step('0); step(ON); step(ON | I_PAUSE);
        check("rst pause entry", 32'(o_state), 32'(S_PAUSE));
        step(I_RST | I_PAUSE);
        check("rst pause flag", 32'(o_paused), 0);
        step(I_PAUSE); step(I_PAUSE); step(ON);
        check("rst pause resume", 32'(o_state), 32'(S_RUN));
        check("rst no tick", 32'(tick_seen), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            stim_t s;
            s = '0;
            if ($urandom_range(0, 499) == 0) s |= I_RST;
            if ($urandom_range(0, 79) == 0)  s |= I_RESTART;
            if ($urandom_range(0, 1) == 0)   s |= I_START;
            if ($urandom_range(0, 9) != 0)   s |= I_APPLE;
            if ($urandom_range(0, 2) == 0)   s |= I_VSYNC;
            if ($urandom_range(0, 7) == 0)   s |= I_PAUSE;
            if ($urandom_range(0, 5) == 0)   s |= I_TDONE;
            if ($urandom_range(0, 149) == 0) s |= I_SFAIL;
            if ($urandom_range(0, 149) == 0) s |= I_SWIN;
            if ($urandom_range(0, 3) == 0)   s |= I_EAT;
            if ($urandom_range(0, 11) == 0)  s |= I_UP;
            if ($urandom_range(0, 11) == 0)  s |= I_DOWN;
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/game_seq.md
GAME_SEQ -- requirements
Module: game_seq

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: i_vsync  in  1  one-cycle pulse per VGA frame.
REQ-004 SHALL have port: i_pause  in  1  level; high = pause requested.
REQ-005 SHALL have port: i_restart  in  1  level; high = restart game.
REQ-006 SHALL have port: i_start  in  1  level from control; high = first direction entered.
REQ-007 SHALL have port: i_apple_ready  in  1  apple placement valid.
REQ-008 SHALL have port: i_tick_done  in  1  one-cycle pulse; snake scan restarted (pos_first).
REQ-009 SHALL have ports: i_snake_failure, i_snake_success, i_eat  in  1 each  one-cycle event pulses.
REQ-010 SHALL have ports: i_speed_up, i_speed_down  in  1 each  one-cycle pulses.
REQ-011 SHALL have ports: o_tick  out  1  one-cycle game step; o_game_rst  out  1  active-high reset to snake/apple/control.
REQ-012 SHALL have ports: o_state  out  3  current FSM state; o_failure, o_success, o_paused  out  1 each.
REQ-013 SHALL have ports: o_score  out  8  apples eaten; o_level  out  3  speed level.
REQ-014 SHALL have parameter: BUSY_TIMEOUT, default 1023, max cycles waited in BUSY.

Function
REQ-015 SHALL implement states GRST, WAIT, RUN, BUSY, PAUSE, FAIL, WIN.
REQ-016 GRST SHALL assert o_game_rst for exactly 2 cycles, clear o_score/frame counter, then enter WAIT.
REQ-017 i_restart high in any state SHALL enter GRST next cycle; held high SHALL keep FSM in GRST, o_game_rst asserted.
REQ-018 WAIT SHALL move to RUN when i_start high and i_apple_ready high.
REQ-019 Ticks SHALL occur every P = 16 - 2*o_level frames (level 0..7 -> 16..2).
REQ-020 RUN SHALL count i_vsync pulses modulo P; on the vsync completing the period, o_tick SHALL pulse the next cycle and FSM SHALL enter BUSY, provided i_apple_ready high.
REQ-021 Period completing while i_apple_ready low SHALL drop that tick (no o_tick), reset frame count, stay in RUN.
REQ-022 BUSY SHALL return to RUN on i_tick_done; after BUSY_TIMEOUT cycles without it SHALL return to RUN anyway.
REQ-023 At most one o_tick SHALL be issued per BUSY entry; no o_tick outside RUN->BUSY transition.
REQ-024 i_pause high in RUN SHALL enter PAUSE; in BUSY SHALL defer PAUSE until BUSY exits; PAUSE SHALL freeze frame count and return to RUN when i_pause low.
REQ-025 i_snake_failure in RUN or BUSY SHALL enter FAIL; i_snake_success SHALL enter WIN; simultaneous: FAIL wins.
REQ-026 FAIL and WIN SHALL be absorbing until i_restart; o_failure=1 in FAIL, o_success=1 in WIN, o_paused=1 in PAUSE only.
REQ-027 i_eat SHALL increment o_score, saturating at 255, in any state except GRST.
REQ-028 i_speed_up/i_speed_down SHALL inc/dec o_level saturating 0..7; simultaneous pulses SHALL leave level unchanged; new P applies from next period.
REQ-029 o_level SHALL be unaffected by i_restart.

Reset
REQ-030 rst SHALL force: state GRST, o_tick=0, o_game_rst=1, o_score=0, o_level=3, frame count 0, flags 0.
REQ-031 rst mid-BUSY or mid-PAUSE SHALL discard pending tick/pause with no o_tick emitted.

Structure
REQ-032 game_state_t enum, level min/max/reset, GRST length SHALL reside in the shared common package.
REQ-033 Frame counting SHALL be one sub-module, frame_divider (inputs vsync, enable, clear, period; output due pulse).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 rst, level 3 (P=10), i_start=1, apple ready: 10 vsyncs -> exactly one o_tick, state BUSY; i_tick_done -> RUN.
REQ-036 i_apple_ready=0 across period end -> no o_tick, state RUN, next tick after 10 further vsyncs.
REQ-037 i_pause during BUSY -> PAUSE only after i_tick_done; 30 vsyncs in PAUSE -> no o_tick, o_paused=1.
REQ-038 i_snake_failure and i_snake_success same cycle -> FAIL, o_failure=1, o_success=0; i_restart 1 cycle -> o_game_rst 2 cycles, WAIT.
REQ-039 300 i_eat pulses -> o_score=255; 9 i_speed_up -> o_level=7, P=2; restart -> score 0, level 7.
REQ-040 BUSY with no i_tick_done -> RUN after exactly BUSY_TIMEOUT cycles.
